// File: rtl/fpu_pkg.sv
// Shared constants and types for the single-precision multiplier output stage.
// Flag vectors are ordered {invalid, overflow, zero}.
package fpu_pkg;

  localparam int          EXP_MAX     = 255;
  localparam int          EXP_BIAS    = 127;
  localparam logic [31:0] QNAN32      = 32'h7FC0_0000;

  localparam int          FLG_INVALID  = 2;
  localparam int          FLG_OVERFLOW = 1;
  localparam int          FLG_ZERO     = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  flags;
  } fifo_entry_t;

endpackage

// File: rtl/fpu_result_fifo.sv
// Parameterised synchronous FIFO holding packed results with their flags.
// The head entry reads as zero whenever the FIFO is empty.
module fpu_result_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  fifo_entry_t wdata_i,
  output fifo_entry_t rdata_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  fifo_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic               doPush;
  logic               doPop;

  assign full_o  = (count_q == OCC_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/fmul_result_pack.sv
// Packs the multiplier's unpacked result into binary32, buffers it behind a
// valid/ready FIFO, and keeps sticky exception flags and an accept counter.
module fmul_result_pack
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [7:0]       in_exp,
  input  logic [23:0]      in_frac,
  input  logic             in_error,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [2:0]       out_flags,
  output logic [2:0]       sticky_flags,
  input  logic             flags_clr,
  output logic [CNT_W-1:0] result_cnt
);

  fifo_entry_t      packed_d;
  fifo_entry_t      head;
  logic             push;
  logic             pop;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [2:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] resultCnt_q;
  logic             unused_hiddenBit;

  assign unused_hiddenBit = in_frac[23];

  // First matching case wins; NaN output is canonical with the sign dropped.
  always_comb begin
    packed_d = '0;
    if (in_error) begin
      packed_d.data               = QNAN32;
      packed_d.flags[FLG_INVALID] = 1'b1;
    end else if (in_overflow) begin
      packed_d.data                = {in_sign, 8'hFF, 23'h0};
      packed_d.flags[FLG_OVERFLOW] = 1'b1;
    end else if (in_exp == 8'(EXP_MAX)) begin
      packed_d.data = {in_sign, 8'hFF, in_frac[22:0]};
    end else if (in_exp == 8'h00) begin
      packed_d.data            = {in_sign, 31'h0};
      packed_d.flags[FLG_ZERO] = 1'b1;
    end else begin
      packed_d.data = {in_sign, in_exp, in_frac[22:0]};
    end
  end

  assign in_ready  = ~fifoFull;
  assign out_valid = ~fifoEmpty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = head.data;
  assign out_flags = head.flags;

  fpu_result_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (packed_d),
    .rdata_o (head),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // A flag set by this cycle's push survives a coincident clear.
  assign sticky_d = (flags_clr ? 3'b000 : sticky_q) | (push ? packed_d.flags : 3'b000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q    <= '0;
      resultCnt_q <= '0;
    end else begin
      sticky_q <= sticky_d;
      if (push) resultCnt_q <= resultCnt_q + CNT_W'(1);
    end
  end

  assign sticky_flags = sticky_q;
  assign result_cnt   = resultCnt_q;

endmodule

// File: tb/tb_fmul_result_pack.sv
// Directed self-checking bench for fmul_result_pack with DEPTH=2.
// Inputs change #1 after the rising edge; outputs are sampled at that point.
module tb_fmul_result_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [23:0] in_frac;
  logic        in_error, in_overflow;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_flags, sticky_flags;
  logic        flags_clr;
  logic [15:0] result_cnt;

  int testsRun    = 0;
  int testsFailed = 0;

  fmul_result_pack #(.DEPTH(2), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_frac      (in_frac),
    .in_error     (in_error),
    .in_overflow  (in_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .flags_clr    (flags_clr),
    .result_cnt   (result_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setInputs(input logic s, input logic [7:0] e, input logic [23:0] f,
                           input logic err, input logic ovf);
    in_sign     = s;
    in_exp      = e;
    in_frac     = f;
    in_error    = err;
    in_overflow = ovf;
  endtask

  // One-cycle push, leaving the outputs sampled right after the accepting edge.
  task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [23:0] f,
                               input logic err, input logic ovf);
    setInputs(s, e, f, err, ovf);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flags_clr = 1'b0;
    setInputs(1'b0, 8'h00, 24'h0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", out_data, 32'h0);
    checkOutput("reset out_flags", 32'(out_flags), 32'd0);
    checkOutput("reset sticky", 32'(sticky_flags), 32'd0);
    checkOutput("reset cnt", 32'(result_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Normal result and one-cycle latency
    out_ready = 1'b1;
    applyStimulus(1'b1, 8'h80, 24'hC00000, 1'b0, 1'b0);
    checkOutput("normal valid", 32'(out_valid), 32'd1);
    checkOutput("normal data", out_data, 32'hC040_0000);
    checkOutput("normal flags", 32'(out_flags), 32'd0);
    checkOutput("normal cnt", 32'(result_cnt), 32'd1);
    tick();
    checkOutput("normal drained", 32'(out_valid), 32'd0);
    checkOutput("empty data zero", out_data, 32'h0);

    // Invalid operation and sticky behaviour
    applyStimulus(1'b1, 8'h10, 24'h800000, 1'b1, 1'b0);
    checkOutput("nan data", out_data, 32'h7FC0_0000);
    checkOutput("nan flags", 32'(out_flags), 32'd4);
    checkOutput("nan sticky", 32'(sticky_flags), 32'd4);
    tick();
    checkOutput("sticky holds", 32'(sticky_flags), 32'd4);
    flags_clr = 1'b1;
    applyStimulus(1'b0, 8'h20, 24'h800000, 1'b1, 1'b0);
    flags_clr = 1'b0;
    checkOutput("clr vs set", 32'(sticky_flags), 32'd4);
    tick();
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    checkOutput("clr alone", 32'(sticky_flags), 32'd0);

    // Overflow, zero and inf*inf
    applyStimulus(1'b0, 8'h40, 24'h800000, 1'b0, 1'b1);
    checkOutput("ovf data", out_data, 32'h7F80_0000);
    checkOutput("ovf flags", 32'(out_flags), 32'd2);
    tick();
    applyStimulus(1'b1, 8'h00, 24'h812345, 1'b0, 1'b0);
    checkOutput("zero data", out_data, 32'h8000_0000);
    checkOutput("zero flags", 32'(out_flags), 32'd1);
    tick();
    applyStimulus(1'b0, 8'hFF, 24'h800000, 1'b0, 1'b0);
    checkOutput("inf data", out_data, 32'h7F80_0000);
    checkOutput("inf flags", 32'(out_flags), 32'd0);
    checkOutput("sticky ovf|zero", 32'(sticky_flags), 32'd3);
    checkOutput("cnt after 6", 32'(result_cnt), 32'd6);
    tick();

    // Back-pressure with a full FIFO
    out_ready = 1'b0;
    applyStimulus(1'b0, 8'h81, 24'h800000, 1'b0, 1'b0);
    checkOutput("bp ready after 1", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 8'h82, 24'hA00000, 1'b0, 1'b0);
    checkOutput("bp ready after 2", 32'(in_ready), 32'd0);
    checkOutput("bp head A", out_data, 32'h4080_0000);
    setInputs(1'b1, 8'h7F, 24'h800000, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    checkOutput("bp stall ready", 32'(in_ready), 32'd0);
    checkOutput("bp head stable", out_data, 32'h4080_0000);
    checkOutput("bp stall cnt", 32'(result_cnt), 32'd8);
    out_ready = 1'b1;
    tick();
    checkOutput("bp head B", out_data, 32'h4120_0000);
    checkOutput("bp cnt no push", 32'(result_cnt), 32'd8);
    checkOutput("bp ready again", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("bp head C", out_data, 32'hBF80_0000);
    checkOutput("bp cnt C", 32'(result_cnt), 32'd9);
    tick();
    checkOutput("bp drained", 32'(out_valid), 32'd0);

    // Streaming, one result per cycle with occupancy held at one
    for (int i = 0; i < 10; i++) begin
      setInputs(1'b0, 8'h90 + 8'(i), 24'h800000 | 24'(i), 1'b0, 1'b0);
      in_valid = 1'b1;
      tick();
      checkOutput($sformatf("stream data %0d", i), out_data,
                  ((32'h90 + 32'(i)) << 23) | 32'(i));
      checkOutput($sformatf("stream occ %0d", i), 32'({out_valid, in_ready}), 32'd3);
    end
    in_valid = 1'b0;
    tick();
    checkOutput("stream drained", 32'(out_valid), 32'd0);
    checkOutput("stream cnt", 32'(result_cnt), 32'd19);

    // Asynchronous reset with two entries buffered
    out_ready = 1'b0;
    applyStimulus(1'b0, 8'h85, 24'h800000, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h86, 24'h800000, 1'b0, 1'b1);
    checkOutput("pre-rst full", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst cnt", 32'(result_cnt), 32'd0);
    checkOutput("rst out_data", out_data, 32'h0);
    checkOutput("rst sticky", 32'(sticky_flags), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("post-rst empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fmul_result_pack.md
# fmul_result_pack

Output stage directly downstream of the single-precision multiplier datapath. Captures the multiplier's unpacked result (sign, 8-bit exponent, 24-bit fraction with hidden bit, error and overflow strobes). Packs it into a canonical IEEE-754 binary32 word and buffers it in a small FIFO behind a valid/ready handshake. Also accumulates sticky exception flags for software readout.

## Interface

- DEPTH, 2, number of result FIFO entries (power of two, >= 2)
- CNT_W, 16, width of the accepted-result counter

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  multiplier result present this cycle
- in_ready  out  1  stage can accept a result (FIFO not full)
- in_sign  in  1  result sign
- in_exp  in  8  biased result exponent
- in_frac  in  24  fraction, bit 23 = hidden bit
- in_error  in  1  invalid operation (NaN operand or inf*0)
- in_overflow  in  1  exponent overflow
- out_valid  out  1  packed result at FIFO head
- out_ready  in  1  consumer takes head this cycle
- out_data  out  32  packed binary32 result
- out_flags  out  3  flags of head entry {invalid, overflow, zero}
- sticky_flags  out  3  OR of all accepted results' flags, same bit order
- flags_clr  in  1  clear sticky_flags
- result_cnt  out  CNT_W  number of results accepted since reset, wraps

## Operation

- Accept (push) when in_valid & in_ready; pop when out_valid & out_ready.
- Packing is combinational on the inputs and is written into the FIFO at push. Priority, first match wins:
  - in_error: data = 32'h7FC0_0000 (canonical quiet NaN, sign forced 0); flags = 3'b100.
  - in_overflow: data = {in_sign, 8'hFF, 23'h0}; flags = 3'b010.
  - in_exp == 8'hFF: data = {in_sign, 8'hFF, in_frac[22:0]}, which is inf*inf; flags = 3'b000.
  - in_exp == 0: data = {in_sign, 31'h0}; flags = 3'b001.
  - otherwise: data = {in_sign, in_exp, in_frac[22:0]}; flags = 3'b000.
- FIFO: DEPTH entries of 35 bits (data + flags), with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH. Occupancy counter is 0..DEPTH.
- in_ready = (count != DEPTH), taken from registered count only. When full, a simultaneous pop does not enable a push that cycle.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
- out_valid = (count != 0). out_data and out_flags come from the head entry and hold stable while out_valid & ~out_ready.
- sticky_flags <= (flags_clr ? 0 : sticky_flags) | (push ? packed_flags : 0). A set in the same cycle as a clear wins.
- result_cnt increments by 1 on each push and wraps from 2^CNT_W-1 to 0.

## Timing

- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_flags = 0, sticky_flags = 0, result_cnt = 0. Pointers and count are 0.
- Latency: a result pushed in cycle N is visible at out_valid/out_data in cycle N+1 when the FIFO was empty.
- Throughput: one result per cycle when out_ready is held high.
- Reset asserted mid-operation discards all buffered entries immediately, with no further handshakes. Entry contents need not be cleared, but out_data must read 0 while count == 0.
- in_* are sampled only on push; their values are don't-care otherwise.

## Structure

- Shared package fpu_pkg holds:
  - EXP_MAX = 255, EXP_BIAS = 127
  - QNAN32 = 32'h7FC0_0000
  - flag bit indices FLG_INVALID = 2, FLG_OVERFLOW = 1, FLG_ZERO = 0
  - a typedef for the 35-bit FIFO entry
- One sub-module: fpu_result_fifo, a parameterised synchronous FIFO that owns the pointers, count, full and empty logic. The top level holds the packer, sticky flags and counter.

## Test plan

- Normal result sign=1, exp=8'h80, frac=24'hC00000 -> out_data = 32'hC040_0000 one cycle later, flags 000, result_cnt = 1.
- in_error=1 with sign=1, frac=24'h800000 -> out_data = 32'h7FC0_0000, out_flags = 100, sticky_flags[2] = 1 until flags_clr. A flags_clr coincident with another error push leaves sticky_flags = 100.
- in_overflow=1, sign=0 -> 32'h7F80_0000, flags 010. exp=0, sign=1 -> 32'h8000_0000, flags 001.
- Hold out_ready=0 and push 3 results with DEPTH=2 -> in_ready drops after the 2nd push and the 3rd is stalled. out_data is stable. Raise out_ready -> results emerge in order, with no loss or duplication.
- Streaming with in_valid and out_ready both high for 10 cycles -> 10 outputs on consecutive cycles and count stays at 1. Pointers wrap correctly.
- Assert rst with 2 entries buffered -> out_valid = 0 and in_ready = 1 immediately, and result_cnt = 0.
